// File: rtl/frame_sync_if.sv
// Serial bit-stream input and aligned-byte output bundle of the frame sync aligner.
interface frame_sync_if;
    logic       ena;
    logic       serial_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       locked;
    logic [7:0] sync_err_cnt;

    modport master (
        output ena, serial_in,
        input  byte_out, byte_valid, frame_start, locked, sync_err_cnt
    );

    modport slave (
        input  ena, serial_in,
        output byte_out, byte_valid, frame_start, locked, sync_err_cnt
    );
endinterface

// File: rtl/frame_sync_aligner.sv
// Finds byte/frame boundaries in an MSB-first bit stream, locks via HUNT/VERIFY/LOCKED
// and emits aligned payload bytes with a one-cycle valid pulse.
module frame_sync_aligner #(
    parameter logic [7:0] SYNC_WORD     = 8'hA5,
    parameter int         PAYLOAD_LEN   = 4,
    parameter int         VERIFY_FRAMES = 2,
    parameter int         LOSS_MISSES   = 3
) (
    input  logic         clk,
    input  logic         rst,
    frame_sync_if.slave  bus
);
    localparam int VW = $clog2(VERIFY_FRAMES + 1);
    localparam int MW = $clog2(LOSS_MISSES + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t          state, state_d;
    logic [6:0]      sh, sh_d;
    logic [2:0]      bit_cnt, bit_cnt_d;
    logic [7:0]      byte_cnt, byte_cnt_d;
    logic [VW-1:0]   vcnt, vcnt_d;
    logic [MW-1:0]   miss, miss_d;
    logic [7:0]      byte_out, byte_out_d;
    logic            byte_valid, byte_valid_d;
    logic            frame_start, frame_start_d;
    logic            locked, locked_d;
    logic [7:0]      err_cnt, err_cnt_d;

    logic [7:0]      nxt;
    logic            byte_done;
    logic            sync_slot;
    logic            match;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d       = state;
        sh_d          = sh;
        bit_cnt_d     = bit_cnt;
        byte_cnt_d    = byte_cnt;
        vcnt_d        = vcnt;
        miss_d        = miss;
        byte_out_d    = byte_out;
        byte_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        locked_d      = locked;
        err_cnt_d     = err_cnt;

        nxt       = {sh, bus.serial_in};
        byte_done = bus.ena && (bit_cnt == 3'd7);
        sync_slot = byte_done && (byte_cnt == 8'(PAYLOAD_LEN));
        match     = (nxt == SYNC_WORD);

        if (bus.ena) begin
            sh_d      = nxt[6:0];
            bit_cnt_d = bit_cnt + 3'd1;
            if (byte_done)
                byte_cnt_d = sync_slot ? 8'd0 : byte_cnt + 8'd1;

            unique case (state)
                HUNT: begin
                    // Sliding one-bit search; a hit defines the byte grid from here on
                    if (match) begin
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 8'd0;
                        vcnt_d     = '0;
                        state_d    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (sync_slot) begin
                        if (match) begin
                            vcnt_d = vcnt + VW'(1);
                            if (vcnt_d == VW'(VERIFY_FRAMES)) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                miss_d   = '0;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (byte_done && !sync_slot) begin
                        byte_out_d    = nxt;
                        byte_valid_d  = 1'b1;
                        frame_start_d = (byte_cnt == 8'd0);
                    end
                    // A tolerated miss keeps the old alignment; only a run of misses drops lock
                    if (sync_slot) begin
                        if (match) begin
                            miss_d = '0;
                        end else begin
                            miss_d    = miss + MW'(1);
                            err_cnt_d = sat_inc8(err_cnt);
                            if (miss_d == MW'(LOSS_MISSES)) begin
                                state_d  = HUNT;
                                locked_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            sh          <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            vcnt        <= '0;
            miss        <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state       <= state_d;
            sh          <= sh_d;
            bit_cnt     <= bit_cnt_d;
            byte_cnt    <= byte_cnt_d;
            vcnt        <= vcnt_d;
            miss        <= miss_d;
            byte_out    <= byte_out_d;
            byte_valid  <= byte_valid_d;
            frame_start <= frame_start_d;
            locked      <= locked_d;
            err_cnt     <= err_cnt_d;
        end
    end

    assign bus.byte_out     = byte_out;
    assign bus.byte_valid   = byte_valid;
    assign bus.frame_start  = frame_start;
    assign bus.locked       = locked;
    assign bus.sync_err_cnt = err_cnt;
endmodule
